// File: rtl/moore_stim_driver_pkg.sv
// -----------------------------------------------------------------------------
// moore_stim_driver_pkg
// Shared definitions for the Moore FSM stimulus driver:
//   - state_t : 3-bit state encoding of the driver sequencer
//   - clog2   : bit width needed to hold values 0..value-1 (minimum 1)
// -----------------------------------------------------------------------------
package moore_stim_driver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Number of bits needed to represent 0..value-1; never returns less than 1
   // so a degenerate counter still has a legal vector width.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/moore_stim_driver_stim_shift_reg.sv
// -----------------------------------------------------------------------------
// stim_shift_reg
// Parallel-load, LSB-first serial-out register holding the stimulus pattern.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset, clears the register
//   load   : load din into the register (has priority over shift)
//   shift  : shift the register one place toward bit 0
//   din    : parallel pattern
//   lsb    : current bit 0, i.e. the next bit to be sent
// -----------------------------------------------------------------------------
module stim_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             lsb
);

   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= din;
      end else if (shift) begin
         // zero-fill from the top; the vacated bits are never sent
         sreg <= sreg >> 1;
      end
   end

   assign lsb = sreg[0];

endmodule

// File: rtl/moore_stim_driver.sv
// -----------------------------------------------------------------------------
// moore_stim_driver
// Bit-serial stimulus transmitter and response collector for single-input /
// single-output Moore FSMs. A WIDTH-bit pattern accepted on start/ready is
// sent LSB-first on x_out after a one-cycle dut_reset pulse; y_in is sampled
// LAT cycles after each bit and assembled into response.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   start     : run request, accepted only while ready=1
//   pattern   : stimulus word, bit 0 sent first, sampled on the accept edge
//   ready     : high in IDLE only
//   dut_reset : one-cycle reset pulse to the FSM under test
//   x_out     : serial stimulus bit
//   y_in      : FSM under test output
//   response  : collected samples, response[k] answers pattern bit k
//   done      : one-cycle pulse when response is complete
//   busy      : high from PRIME through DONE
// All outputs are registered.
// -----------------------------------------------------------------------------
module moore_stim_driver
   import moore_stim_driver_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   output logic             ready,
   output logic             dut_reset,
   output logic             x_out,
   input  logic             y_in,
   output logic [WIDTH-1:0] response,
   output logic             done,
   output logic             busy
);

   // counter spans the SHIFT and DRAIN phases: 0 .. WIDTH+LAT-1
   localparam int             CW         = clog2(WIDTH + LAT + 1);
   localparam logic [CW-1:0]  LAST_SHIFT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  LAST_DRAIN = CW'(WIDTH + LAT - 1);
   localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;
   logic [WIDTH-1:0] response_nx;
   logic             x_nx;
   logic             sr_load;
   logic             sr_shift;
   logic             sr_lsb;
   logic             sample;
   int               ridx;

   stim_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk   (clk),
      .reset (reset),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (pattern),
      .lsb   (sr_lsb)
   );

   // Next-state, next-output and response-capture logic.
   // x_out is registered, so the bit for cycle c+1 is taken from the shift
   // register at the edge ending cycle c; the shift register therefore always
   // holds the not-yet-driven bits with the next one at bit 0.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      response_nx = response;
      x_nx        = 1'b0;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      sample      = 1'b0;
      ridx        = int'(cnt) - LAT;

      case (state)
         ST_IDLE: begin
            if (start) begin
               sr_load     = 1'b1;
               response_nx = '0;
               cnt_nx      = '0;
               state_nx    = ST_PRIME;
            end
         end

         ST_PRIME: begin
            x_nx     = sr_lsb;
            sr_shift = 1'b1;
            state_nx = ST_SHIFT;
         end

         ST_SHIFT: begin
            sample = (int'(cnt) >= LAT);
            cnt_nx = cnt + CNT_ONE;
            if (cnt == LAST_SHIFT) begin
               state_nx = (LAT > 0) ? ST_DRAIN : ST_DONE;
            end else begin
               x_nx     = sr_lsb;
               sr_shift = 1'b1;
            end
         end

         ST_DRAIN: begin
            // only the trailing samples remain; x_out already idles at 0
            sample = (int'(cnt) >= LAT);
            cnt_nx = cnt + CNT_ONE;
            if (cnt == LAST_DRAIN) begin
               state_nx = ST_DONE;
            end
         end

         ST_DONE: begin
            state_nx = ST_IDLE;
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      // the sample taken at the end of cycle c answers the bit sent in c-LAT
      if (sample) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (ridx == k) begin
               response_nx[k] = y_in;
            end
         end
      end
   end

   // State, counter, response and registered outputs. The status outputs are
   // decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         response  <= '0;
         x_out     <= 1'b0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         dut_reset <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         response  <= response_nx;
         x_out     <= x_nx;
         ready     <= (state_nx == ST_IDLE);
         busy      <= (state_nx != ST_IDLE);
         done      <= (state_nx == ST_DONE);
         dut_reset <= (state_nx == ST_PRIME);
      end
   end

endmodule

// File: tb/tb_moore_stim_driver.sv
// -----------------------------------------------------------------------------
// tb_moore_stim_driver
// Self-checking bench for moore_stim_driver. Two instances: LAT=2 (a_*) and
// LAT=0 (b_*), both WIDTH=8. The expected per-cycle timeline of a run is
// derived from the accept edge: cycle 1 PRIME, cycles 2..W+1 carry the
// pattern bits, then LAT drain cycles, one DONE cycle, then IDLE.
// y_in modes: 0 tied low, 1 tied high, 2 loopback (x_out delayed by LAT),
// 3 random bits chosen per cycle by the bench.
// -----------------------------------------------------------------------------
module tb_moore_stim_driver;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         start;
   logic         sel;
   logic [W-1:0] pattern;
   int           ymode;
   logic         yr_cur;

   logic         start_a, start_b;
   logic         y_a, y_b;
   logic         a_ready, a_dut_reset, a_x, a_done, a_busy;
   logic         b_ready, b_dut_reset, b_x, b_done, b_busy;
   logic [W-1:0] a_resp, b_resp;
   logic         xd1, xd2;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   moore_stim_driver #(.WIDTH(W), .LAT(2)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .pattern(pattern),
      .ready(a_ready), .dut_reset(a_dut_reset), .x_out(a_x), .y_in(y_a),
      .response(a_resp), .done(a_done), .busy(a_busy)
   );

   moore_stim_driver #(.WIDTH(W), .LAT(0)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .pattern(pattern),
      .ready(b_ready), .dut_reset(b_dut_reset), .x_out(b_x), .y_in(y_b),
      .response(b_resp), .done(b_done), .busy(b_busy)
   );

   // two-cycle loopback delay line for the LAT=2 instance
   always @(posedge clk) begin
      xd1 <= a_x;
      xd2 <= xd1;
   end

   always_comb begin
      y_a = 1'b0;
      y_b = 1'b0;
      case (ymode)
         1: begin y_a = 1'b1;   y_b = 1'b1;   end
         2: begin y_a = xd2;    y_b = b_x;    end
         3: begin y_a = yr_cur; y_b = yr_cur; end
         default: begin y_a = 1'b0; y_b = 1'b0; end
      endcase
   end

   logic         o_ready, o_dut_reset, o_x, o_done, o_busy;
   logic [W-1:0] o_resp;
   assign o_ready     = sel ? b_ready     : a_ready;
   assign o_dut_reset = sel ? b_dut_reset : a_dut_reset;
   assign o_x         = sel ? b_x         : a_x;
   assign o_done      = sel ? b_done      : a_done;
   assign o_busy      = sel ? b_busy      : a_busy;
   assign o_resp      = sel ? b_resp      : a_resp;

   int  checks = 0;
   int  errors = 0;
   time last_done_t = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One run on the selected instance. repulse_n: cycle in which start is
   // re-asserted with 8'h3C (ignored by the DUT). reset_n: cycle in which
   // reset is asserted mid-run. hold: keep start high throughout.
   task automatic run(input logic [W-1:0] pat, input int mode, input bit hold,
                      input int repulse_n, input int reset_n);
      int           lat;
      int           last;
      int           waited;
      logic         yr [0:31];
      logic [W-1:0] exp_r;

      lat    = sel ? 0 : 2;
      last   = W + lat + 3;
      ymode  = mode;
      waited = 0;
      while (o_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (o_ready !== 1'b1) begin
         check_eq("ready_wait", {31'd0, o_ready}, 32'd1);
         return;
      end
      start  = 1'b1;
      pattern = pat;
      yr[0]  = 1'($urandom);
      yr_cur = yr[0];
      @(posedge clk);
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         if (n == reset_n) begin
            reset = 1'b1;
            start = 1'b0;
            #1;
            check_eq("rst_ready", {31'd0, o_ready}, 32'd1);
            check_eq("rst_busy",  {31'd0, o_busy},  32'd0);
            check_eq("rst_x",     {31'd0, o_x},     32'd0);
            check_eq("rst_done",  {31'd0, o_done},  32'd0);
            check_eq("rst_dutrst", {31'd0, o_dut_reset}, 32'd0);
            check_eq("rst_resp",  {24'd0, o_resp},  32'd0);
            @(negedge clk);
            reset = 1'b0;
            repeat (W + lat + 4) begin
               @(negedge clk);
               check_eq("post_rst_done",  {31'd0, o_done},  32'd0);
               check_eq("post_rst_ready", {31'd0, o_ready}, 32'd1);
               check_eq("post_rst_dutrst", {31'd0, o_dut_reset}, 32'd0);
            end
            return;
         end
         check_eq($sformatf("x_n%0d", n), {31'd0, o_x},
                  {31'd0, (n >= 2 && n <= W + 1) ? pat[n-2] : 1'b0});
         check_eq($sformatf("dutrst_n%0d", n), {31'd0, o_dut_reset}, {31'd0, n == 1});
         check_eq($sformatf("done_n%0d", n),   {31'd0, o_done},  {31'd0, n == W + lat + 2});
         check_eq($sformatf("busy_n%0d", n),   {31'd0, o_busy},  {31'd0, n <= W + lat + 2});
         check_eq($sformatf("ready_n%0d", n),  {31'd0, o_ready}, {31'd0, n == last});
         if (n >= W + lat + 2) begin
            for (int k = 0; k < W; k++) begin
               case (mode)
                  0:       exp_r[k] = 1'b0;
                  1:       exp_r[k] = 1'b1;
                  2:       exp_r[k] = pat[k];
                  default: exp_r[k] = yr[k + 2 + lat];
               endcase
            end
            check_eq($sformatf("resp_n%0d", n), {24'd0, o_resp}, {24'd0, exp_r});
            if (n == W + lat + 2) last_done_t = $time;
         end
         start   = hold ? 1'b1 : (n == repulse_n);
         pattern = (n == repulse_n) ? 8'h3C : W'($urandom);
         yr[n]   = 1'($urandom);
         yr_cur  = yr[n];
      end
   endtask

   initial begin : main
      time t_first;
      reset   = 1'b1;
      start   = 1'b0;
      sel     = 1'b0;
      pattern = '0;
      ymode   = 0;
      yr_cur  = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("reset_a_ready",  {31'd0, a_ready},  32'd1);
      check_eq("reset_a_busy",   {31'd0, a_busy},   32'd0);
      check_eq("reset_a_x",      {31'd0, a_x},      32'd0);
      check_eq("reset_a_done",   {31'd0, a_done},   32'd0);
      check_eq("reset_a_dutrst", {31'd0, a_dut_reset}, 32'd0);
      check_eq("reset_a_resp",   {24'd0, a_resp},   32'd0);
      check_eq("reset_b_ready",  {31'd0, b_ready},  32'd1);
      check_eq("reset_b_resp",   {24'd0, b_resp},   32'd0);
      reset = 1'b0;
      @(negedge clk);

      // loopback, tied inputs, ignored re-start
      run(8'hA5, 2, 1'b0, -1, -1);
      run(8'h00, 1, 1'b0, -1, -1);
      run(8'hFF, 0, 1'b0, -1, -1);
      run(8'h81, 2, 1'b0, 5, -1);

      // start held high: back-to-back runs one IDLE cycle apart
      run(8'h12, 2, 1'b1, -1, -1);
      t_first = last_done_t;
      run(8'h34, 2, 1'b0, -1, -1);
      check_eq("done_gap", 32'((last_done_t - t_first) / 10), 32'd13);

      // reset during SHIFT cycle 4, then a clean run
      run(8'h5A, 2, 1'b0, -1, 6);
      run(8'h5A, 2, 1'b0, -1, -1);

      // LAT=0 with combinational loopback
      sel = 1'b1;
      @(negedge clk);
      run(8'hC3, 2, 1'b0, -1, -1);

      // randomized runs on both instances
      for (int i = 0; i < 16; i++) begin
         sel = 1'($urandom);
         @(negedge clk);
         run(W'($urandom), int'($urandom_range(0, 3)), 1'b0, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/moore_stim_driver.md
Name: moore_stim_driver

Overview:
- Bit-serial stimulus transmitter and response collector for the team's single-input/single-output Moore FSMs (input x, output y).
- Accepts a WIDTH-bit pattern on a start/ready handshake and pulses a one-cycle reset to the FSM under test.
- Drives the pattern LSB-first on x_out, one bit per clock, and captures y_in LAT cycles after each bit into a WIDTH-bit response word.
- Sits between the testbench/sequence controller and the FSM under test.

Parameters:
- WIDTH, 8: pattern and response length in bits; range 1..32.
- LAT, 2: cycles from a bit appearing on x_out to its sampled y_in; range 0..7.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to run a pattern; accepted only when ready=1.
- pattern  input  WIDTH  stimulus word; bit 0 is sent first; sampled on the accept edge.
- ready  output  1  high in IDLE only.
- dut_reset  output  1  registered one-cycle reset pulse to the FSM under test.
- x_out  output  1  registered serial stimulus bit.
- y_in  input  1  FSM under test output.
- response  output  WIDTH  collected y samples; response[k] answers pattern bit k.
- done  output  1  one-cycle pulse when response is complete.
- busy  output  1  high in PRIME, SHIFT, DRAIN and DONE.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, busy=0, dut_reset=0, x_out=0, done=0, response=0, cycle counter=0, pattern register=0.
- All outputs are registered. The cycle counter is wide enough to hold WIDTH+LAT.
- IDLE:
  - On start=1 at a clock edge: latch pattern into the shift register, clear response and counter, set dut_reset<=1, go to PRIME.
  - start=0: remain in IDLE, x_out=0.
- PRIME (exactly 1 cycle):
  - dut_reset=1 during this cycle.
  - At the edge: dut_reset<=0, x_out<=pattern[0], go to SHIFT.
- SHIFT and DRAIN share counter c, starting at 0 on the first SHIFT cycle.
  - During cycle c with c<WIDTH: x_out=pattern[c].
  - At the end of cycle c=WIDTH-1: x_out<=0 and the state leaves SHIFT. It enters DRAIN if LAT>0, otherwise DONE.
  - Sampling: at the edge ending cycle c, if c>=LAT then response[c-LAT]<=y_in.
  - DRAIN lasts LAT cycles, with x_out=0.
  - Leave DRAIN at the end of cycle c=WIDTH+LAT-1, going to DONE.
- DONE (1 cycle): done=1, busy=1. Then go to IDLE.
- response holds its value from the DONE cycle until the next accepted start clears it.
- Latency: the start edge to the done pulse is 1+WIDTH+LAT+1 cycles. Example: WIDTH=8, LAT=2 gives done high in the 12th cycle after the accept edge.
- Boundary conditions:
  - start while busy is ignored: no queuing, pattern is not re-latched.
  - start held high continuously gives back-to-back runs separated by exactly one IDLE cycle.
  - Changes on pattern after acceptance have no effect.
  - LAT=0: y_in is sampled in the same cycle its bit is driven; DRAIN is skipped.
  - WIDTH=1: a single SHIFT cycle.
  - Reset asserted mid-run: immediate return to the reset values above. dut_reset is not pulsed, partial response is discarded, and done is not generated.
  - x/z on y_in is captured as-is; no checking.

Decomposition:
- Shared package holds the state encoding as named 3-bit constants: ST_IDLE=0, ST_PRIME=1, ST_SHIFT=2, ST_DRAIN=3, ST_DONE=4. It also holds a clog2 helper for the counter width.
- One natural sub-module, stim_shift_reg: parallel-load, LSB-first serial-out register with load/shift enables. The response capture stays inline.

Test Plan:
1. Loopback (y_in = x_out delayed 2 cycles by the bench), WIDTH=8, LAT=2, pattern=8'hA5: dut_reset high 1 cycle; x_out sequence 1,0,1,0,0,1,0,1; done 12 cycles after the accept edge; response=8'hA5.
2. y_in tied 1, pattern=8'h00: response=8'hFF, x_out stays 0 throughout. y_in tied 0, pattern=8'hFF: response=8'h00.
3. start re-pulsed in SHIFT cycle 3 with pattern=8'h3C during a run of 8'h81: ignored; response=8'h81 in loopback; ready stays 0 until after done.
4. start held high, patterns 8'h12 then 8'h34: two done pulses 13 cycles apart; responses 8'h12 then 8'h34; exactly one ready=1 cycle between runs.
5. reset asserted during SHIFT cycle 4: next observed values are ready=1, busy=0, x_out=0, response=0, and no done pulse. A following run of 8'h5A completes correctly.
6. LAT=0 with combinational loopback (y_in=x_out), pattern=8'hC3: no DRAIN state visited; done 10 cycles after accept; response=8'hC3.
